// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory port signals of the arbiter, grouped with arbiter/environment views
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_resp_data;
  logic                ls_req_valid;
  logic [ADDR_W-1:0]   ls_req_addr;
  logic                ls_req_wen;
  logic [DATA_W-1:0]   ls_req_wdata;
  logic [DATA_W/8-1:0] ls_req_wmask;
  logic                ls_req_ready;
  logic                ls_resp_valid;
  logic [DATA_W-1:0]   ls_resp_rdata;
  logic                mem_req_valid;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic                mem_req_wen;
  logic [DATA_W-1:0]   mem_req_wdata;
  logic [DATA_W/8-1:0] mem_req_wmask;
  logic                mem_req_ready;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_resp_rdata;
  logic                busy;
  modport master (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_data,
    input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
    output ls_req_ready, ls_resp_valid, ls_resp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output busy
  );
  modport slave (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_data,
    output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
    input  ls_req_ready, ls_resp_valid, ls_resp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between fetch and load/store, one transaction outstanding
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nx;
  logic last_ls, owner_ls, gnt_if, gnt_ls;
  logic [ADDR_W-1:0] addr;
  logic wen;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wmask;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_ls  <= 1'b1;
      owner_ls <= 1'b0;
      addr     <= '0;
      wen      <= 1'b0;
      wdata    <= '0;
      wmask    <= '0;
    end else begin
      state <= state_nx;
      if (gnt_if || gnt_ls) begin
        last_ls  <= gnt_ls;
        owner_ls <= gnt_ls;
        addr     <= gnt_ls ? bus.ls_req_addr : bus.if_req_addr;
        wen      <= gnt_ls & bus.ls_req_wen;
        wdata    <= gnt_ls ? bus.ls_req_wdata : '0;
        wmask    <= gnt_ls ? bus.ls_req_wmask : '0;
      end
    end
  end
  // a tie goes to whichever requester did not win the previous grant
  always_comb begin
    gnt_if   = !rst && state == IDLE && bus.if_req_valid && (!bus.ls_req_valid || last_ls);
    gnt_ls   = !rst && state == IDLE && bus.ls_req_valid && (!bus.if_req_valid || !last_ls);
    state_nx = state == IDLE ? ((gnt_if || gnt_ls) ? REQ : IDLE) :
               state == REQ  ? (bus.mem_req_ready ? WAIT : REQ) :
                               (bus.mem_resp_valid ? IDLE : WAIT);
  end
  always_comb begin
    bus.if_req_ready  = gnt_if;
    bus.ls_req_ready  = gnt_ls;
    bus.mem_req_valid = state == REQ;
    bus.mem_req_addr  = addr;
    bus.mem_req_wen   = wen;
    bus.mem_req_wdata = wdata;
    bus.mem_req_wmask = wmask;
    bus.if_resp_valid = state == WAIT && bus.mem_resp_valid && !owner_ls;
    bus.ls_resp_valid = state == WAIT && bus.mem_resp_valid && owner_ls;
    bus.if_resp_data  = (state == WAIT && !owner_ls) ? bus.mem_resp_rdata : '0;
    bus.ls_resp_rdata = (state == WAIT && owner_ls) ? bus.mem_resp_rdata : '0;
    bus.busy          = state != IDLE;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions checked against a round-robin transaction model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int xfers = 0;
  int xfers_exp = 0;
  bit last_ls = 1'b1;
  bit g;
  logic [63:0] ia, la, lwd;
  logic [7:0] lwm;
  logic lwen;
  mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();
  mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.mem_req_valid && bus.mem_req_ready) xfers <= xfers + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic no_resp(input string tag);
    chk({tag, "_if_resp"}, 64'(bus.if_resp_valid), 64'd0);
    chk({tag, "_ls_resp"}, 64'(bus.ls_resp_valid), 64'd0);
  endtask

  task automatic abort_now();
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mem_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    no_resp("rst");
    last_ls = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // abort: 0 none, 1 reset while in REQ, 2 reset while in WAIT followed by a late response
  task automatic txn(input bit iv, input bit lv, input int d, input int r, input bit stray,
                     input int abort, input logic [63:0] rd, output bit got_ls);
    bit win_ls;
    logic [63:0] ea;
    logic ewen;
    logic [7:0] ewm;
    win_ls = lv && (!iv || !last_ls);
    ea = win_ls ? la : ia;
    ewen = win_ls & lwen;
    ewm = win_ls ? lwm : 8'h00;
    bus.if_req_valid = iv;
    bus.if_req_addr = ia;
    bus.ls_req_valid = lv;
    bus.ls_req_addr = la;
    bus.ls_req_wen = lwen;
    bus.ls_req_wdata = lwd;
    bus.ls_req_wmask = lwm;
    #1;
    got_ls = bus.ls_req_ready;
    chk("acc_if_ready", 64'(bus.if_req_ready), 64'(!win_ls));
    chk("acc_ls_ready", 64'(bus.ls_req_ready), 64'(win_ls));
    chk("acc_mem_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("acc_busy", 64'(bus.busy), 64'd0);
    last_ls = win_ls;
    xfers_exp++;
    @(posedge clk); #1;
    bus.if_req_addr = {$urandom, $urandom};
    bus.ls_req_addr = {$urandom, $urandom};
    bus.ls_req_wen = 1'($urandom);
    bus.ls_req_wdata = {$urandom, $urandom};
    bus.ls_req_wmask = 8'($urandom);
    for (int k = 0; k <= d; k++) begin
      chk("req_valid", 64'(bus.mem_req_valid), 64'd1);
      chk("req_addr", bus.mem_req_addr, ea);
      chk("req_wen", 64'(bus.mem_req_wen), 64'(ewen));
      chk("req_wmask", 64'(bus.mem_req_wmask), 64'(ewm));
      if (win_ls) chk("req_wdata", bus.mem_req_wdata, lwd);
      chk("req_if_ready", 64'(bus.if_req_ready), 64'd0);
      chk("req_ls_ready", 64'(bus.ls_req_ready), 64'd0);
      chk("req_busy", 64'(bus.busy), 64'd1);
      if (abort == 1) begin
        abort_now();
        xfers_exp--;
        return;
      end
      if (stray && k < d) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = {$urandom, $urandom};
        #1;
        no_resp("stray_req");
        bus.mem_resp_valid = 1'b0;
      end
      bus.mem_req_ready = (k == d);
      @(posedge clk); #1;
    end
    bus.mem_req_ready = 1'b0;
    if (abort == 2) begin
      abort_now();
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = rd;
      #1;
      no_resp("late");
      chk("late_busy", 64'(bus.busy), 64'd0);
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      chk("late_busy_after", 64'(bus.busy), 64'd0);
      return;
    end
    for (int k = 0; k < r; k++) begin
      chk("wait_mem_valid", 64'(bus.mem_req_valid), 64'd0);
      chk("wait_busy", 64'(bus.busy), 64'd1);
      no_resp("wait");
      @(posedge clk); #1;
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = rd;
    #1;
    chk("rsp_if_valid", 64'(bus.if_resp_valid), 64'(!win_ls));
    chk("rsp_ls_valid", 64'(bus.ls_resp_valid), 64'(win_ls));
    chk("rsp_data", win_ls ? bus.ls_resp_rdata : bus.if_resp_data, rd);
    chk("rsp_busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    chk("post_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    bus.if_req_valid = 1'b1;
    bus.if_req_addr = '0;
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr = '0;
    bus.ls_req_wen = 1'b0;
    bus.ls_req_wdata = '0;
    bus.ls_req_wmask = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_ready", 64'(bus.if_req_ready), 64'd0);
    chk("rst_ls_ready", 64'(bus.ls_req_ready), 64'd0);
    chk("rst_mem_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_addr", bus.mem_req_addr, 64'd0);
    chk("idle_wdata", bus.mem_req_wdata, 64'd0);
    chk("idle_wen", 64'(bus.mem_req_wen), 64'd0);
    chk("idle_wmask", 64'(bus.mem_req_wmask), 64'd0);
    no_resp("idle");
    // single fetch
    ia = 64'h8000_0000; la = 64'h1234; lwen = 1'b1; lwd = 64'h55; lwm = 8'h0F;
    txn(1'b1, 1'b0, 0, 2, 1'b0, 0, 64'h0010_0073, g);
    // single store
    la = 64'h8000_0010; lwen = 1'b1; lwd = 64'hDEAD_BEEF_CAFE_F00D; lwm = 8'hFF;
    txn(1'b0, 1'b1, 0, 1, 1'b0, 0, 64'h0, g);
    // back-to-back ties right after reset alternate starting with fetch
    abort_now();
    for (int i = 0; i < 6; i++) begin
      ia = {$urandom, $urandom}; la = {$urandom, $urandom};
      lwen = 1'($urandom); lwd = {$urandom, $urandom}; lwm = 8'($urandom);
      txn(1'b1, 1'b1, 0, 0, 1'b0, 0, {$urandom, $urandom}, g);
      chk("tie_order", 64'(g), 64'(i % 2));
    end
    // slow memory with a stray response while the request waits
    la = 64'hA5A5_0000_0000_0040; lwen = 1'b1; lwd = 64'h0123_4567_89AB_CDEF; lwm = 8'h3C;
    txn(1'b0, 1'b1, 4, 1, 1'b1, 0, 64'h77, g);
    chk("xfer_count", 64'(xfers), 64'(xfers_exp));
    // stray response in IDLE
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'hBAD;
    #1;
    no_resp("stray_idle");
    chk("stray_idle_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    chk("stray_idle_busy_after", 64'(bus.busy), 64'd0);
    chk("stray_idle_mem_valid", 64'(bus.mem_req_valid), 64'd0);
    // reset aborts in REQ and in WAIT, then a tie goes to fetch
    ia = 64'h100; la = 64'h200; lwen = 1'b1; lwd = 64'h9; lwm = 8'h1;
    txn(1'b0, 1'b1, 2, 0, 1'b0, 1, 64'h0, g);
    txn(1'b1, 1'b1, 1, 0, 1'b0, 2, 64'hFEED, g);
    txn(1'b1, 1'b1, 0, 0, 1'b0, 0, 64'h42, g);
    chk("post_abort_tie", 64'(g), 64'd0);
    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit iv, lv;
      int d;
      iv = 1'($urandom);
      lv = iv ? 1'($urandom) : 1'b1;
      d = $urandom_range(0, 3);
      ia = {$urandom, $urandom}; la = {$urandom, $urandom};
      lwen = 1'($urandom); lwd = {$urandom, $urandom}; lwm = 8'($urandom);
      txn(iv, lv, d, $urandom_range(0, 3), (d > 0) && 1'($urandom), 0, {$urandom, $urandom}, g);
    end
    chk("xfer_count_final", 64'(xfers), 64'(xfers_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
